// File: rtl/ppu_pkg.sv
// Shared PPU memory-bus types: PPU modes, requester tags, DMA states.
// Address map constants and region decode helpers.
package ppu_pkg;

  localparam int          OAM_BYTES = 160;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] VRAM_END  = 16'h9FFF;
  localparam logic [7:0]  HIGH_PAGE = 8'hFF;
  localparam logic [7:0]  OAM_LAST  = 8'(OAM_BYTES - 1);

  typedef enum logic [1:0] {
    MODE_HBLANK,
    MODE_VBLANK,
    MODE_OAM_SCAN,
    MODE_DRAW
  } ppu_state_e;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_CPU,
    TAG_PPU,
    TAG_DMA
  } req_tag_e;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_RD,
    DMA_WR
  } dma_state_e;

  function automatic logic in_oam(input logic [15:0] a);
    return (a >= OAM_BASE) && (a < OAM_BASE + 16'(OAM_BYTES));
  endfunction

  function automatic logic in_vram(input logic [15:0] a);
    return (a >= VRAM_BASE) && (a <= VRAM_END);
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: alternating read/write FSM copying one source page
// prefix into OAM; data bypass when the write lands in the response cycle.
module oam_dma_engine
  import ppu_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [7:0]  src_hi_in,
  input  logic        gnt_in,
  input  logic        rsp_valid_in,
  input  logic [7:0]  rsp_data_in,
  output logic        req_out,
  output logic        rd_out,
  output logic        wr_out,
  output logic [15:0] addr_out,
  output logic [7:0]  wdata_out,
  output logic        active_out
);

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src_q, src_d;
  logic [7:0] byte_q, byte_d;

  // State, index, source page and byte latch registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= DMA_IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      byte_q  <= byte_d;
    end
  end

  // Next state: advance on grant, a start restarts from any state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    src_d   = src_q;
    byte_d  = rsp_valid_in ? rsp_data_in : byte_q;
    case (state_q)
      DMA_RD: begin
        if (gnt_in) state_d = DMA_WR;
      end
      DMA_WR: begin
        if (gnt_in) begin
          if (idx_q == OAM_LAST) begin
            state_d = DMA_IDLE;
            idx_d   = '0;
          end else begin
            state_d = DMA_RD;
            idx_d   = idx_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
    if (start_in) begin
      state_d = DMA_RD;
      idx_d   = '0;
      src_d   = src_hi_in;
    end
  end

  // Request outputs decoded from the current state
  always_comb begin
    active_out = (state_q != DMA_IDLE);
    req_out    = active_out;
    rd_out     = (state_q == DMA_RD);
    wr_out     = (state_q == DMA_WR);
    addr_out   = rd_out ? {src_q, idx_q} : OAM_BASE + {8'h00, idx_q};
    wdata_out  = rsp_valid_in ? rsp_data_in : byte_q;
  end

endmodule

// File: rtl/ppu_mem_arbiter.sv
// VRAM/OAM bus arbiter: PPU > DMA > CPU, mode-based access locking,
// and response routing back to the issuing requester.
module ppu_mem_arbiter
  import ppu_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        lcd_en_in,
  input  logic [1:0]  ppu_mode_in,
  input  logic [15:0] cpu_addr_in,
  input  logic        cpu_rd_in,
  input  logic        cpu_wr_in,
  input  logic [7:0]  cpu_wdata_in,
  output logic [7:0]  cpu_rdata_out,
  output logic        cpu_ack_out,
  input  logic [15:0] ppu_addr_in,
  input  logic        ppu_req_in,
  output logic [7:0]  ppu_data_out,
  output logic        ppu_valid_out,
  input  logic        dma_start_in,
  input  logic [7:0]  dma_src_hi_in,
  output logic        dma_active_out,
  output logic [15:0] mem_addr_out,
  output logic        mem_rd_out,
  output logic        mem_wr_out,
  output logic [7:0]  mem_wdata_out,
  input  logic [7:0]  mem_rdata_in,
  input  logic        mem_rvalid_in
);

  req_tag_e tag_q, tag_d;
  logic cpu_blk_q, cpu_blk_d;
  logic cpu_wack_q, cpu_wack_d;
  logic ppu_blk_q, ppu_blk_d;

  logic        dma_req, dma_rd, dma_wr, dma_gnt, dma_rsp;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;

  logic       cpu_busy, ppu_busy, cpu_req, ppu_req;
  logic       oam_lock, vram_lock, cpu_locked, ppu_blk;
  ppu_state_e mode;

  oam_dma_engine u_dma (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (dma_start_in),
    .src_hi_in    (dma_src_hi_in),
    .gnt_in       (dma_gnt),
    .rsp_valid_in (dma_rsp),
    .rsp_data_in  (mem_rdata_in),
    .req_out      (dma_req),
    .rd_out       (dma_rd),
    .wr_out       (dma_wr),
    .addr_out     (dma_addr),
    .wdata_out    (dma_wdata),
    .active_out   (dma_active_out)
  );

  // Response tag and locally generated (no-bus) response flags
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_q      <= TAG_NONE;
      cpu_blk_q  <= 1'b0;
      cpu_wack_q <= 1'b0;
      ppu_blk_q  <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      cpu_blk_q  <= cpu_blk_d;
      cpu_wack_q <= cpu_wack_d;
      ppu_blk_q  <= ppu_blk_d;
    end
  end

  // Lock evaluation and single-winner grant onto the memory bus
  always_comb begin
    mode      = ppu_state_e'(ppu_mode_in);
    cpu_busy  = (tag_q == TAG_CPU) | cpu_blk_q | cpu_wack_q;
    ppu_busy  = (tag_q == TAG_PPU) | ppu_blk_q;
    cpu_req   = (cpu_rd_in | cpu_wr_in) & ~cpu_busy;
    ppu_req   = ppu_req_in & ~ppu_busy;
    oam_lock  = dma_active_out |
                (lcd_en_in & ((mode == MODE_OAM_SCAN) | (mode == MODE_DRAW)));
    vram_lock = lcd_en_in & (mode == MODE_DRAW);
    if (dma_active_out)
      cpu_locked = (cpu_addr_in[15:8] != HIGH_PAGE);
    else
      cpu_locked = (oam_lock & in_oam(cpu_addr_in)) |
                   (vram_lock & in_vram(cpu_addr_in));
    ppu_blk = ppu_req & dma_active_out & in_oam(ppu_addr_in);

    mem_addr_out  = '0;
    mem_rd_out    = 1'b0;
    mem_wr_out    = 1'b0;
    mem_wdata_out = '0;
    dma_gnt       = 1'b0;
    tag_d         = TAG_NONE;
    cpu_wack_d    = 1'b0;
    cpu_blk_d     = cpu_req & cpu_locked;
    ppu_blk_d     = ppu_blk;

    if (ppu_req & ~ppu_blk) begin
      mem_addr_out = ppu_addr_in;
      mem_rd_out   = 1'b1;
      tag_d        = TAG_PPU;
    end else if (dma_req) begin
      dma_gnt      = 1'b1;
      mem_addr_out = dma_addr;
      mem_rd_out   = dma_rd;
      mem_wr_out   = dma_wr;
      if (dma_wr) mem_wdata_out = dma_wdata;
      if (dma_rd) tag_d = TAG_DMA;
    end else if (cpu_req & ~cpu_locked) begin
      mem_addr_out = cpu_addr_in;
      if (cpu_rd_in) begin
        mem_rd_out = 1'b1;
        tag_d      = TAG_CPU;
      end else begin
        mem_wr_out    = 1'b1;
        mem_wdata_out = cpu_wdata_in;
        cpu_wack_d    = 1'b1;
      end
    end
  end

  // Route read data or locked-access responses to the issuer
  always_comb begin
    dma_rsp       = mem_rvalid_in & (tag_q == TAG_DMA);
    cpu_ack_out   = (mem_rvalid_in & (tag_q == TAG_CPU)) |
                    cpu_blk_q | cpu_wack_q;
    ppu_valid_out = (mem_rvalid_in & (tag_q == TAG_PPU)) | ppu_blk_q;
    cpu_rdata_out = '0;
    ppu_data_out  = '0;
    if (mem_rvalid_in & (tag_q == TAG_CPU))
      cpu_rdata_out = mem_rdata_in;
    else if (cpu_blk_q)
      cpu_rdata_out = 8'hFF;
    if (mem_rvalid_in & (tag_q == TAG_PPU))
      ppu_data_out = mem_rdata_in;
    else if (ppu_blk_q)
      ppu_data_out = 8'hFF;
  end

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// Bench for ppu_mem_arbiter: flat 64K memory model with 1-cycle read
// latency, lock rules and DMA copy predicted from address-map arithmetic.
module tb_ppu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        lcd_en;
  logic [1:0]  ppu_mode;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic [15:0] ppu_addr;
  logic        ppu_req;
  logic [7:0]  ppu_data;
  logic        ppu_valid;
  logic        dma_start;
  logic [7:0]  dma_src_hi;
  logic        dma_active;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_rvalid = 1'b0;

  logic [7:0] mem [0:65535];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ppu_mem_arbiter dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .lcd_en_in     (lcd_en),
    .ppu_mode_in   (ppu_mode),
    .cpu_addr_in   (cpu_addr),
    .cpu_rd_in     (cpu_rd),
    .cpu_wr_in     (cpu_wr),
    .cpu_wdata_in  (cpu_wdata),
    .cpu_rdata_out (cpu_rdata),
    .cpu_ack_out   (cpu_ack),
    .ppu_addr_in   (ppu_addr),
    .ppu_req_in    (ppu_req),
    .ppu_data_out  (ppu_data),
    .ppu_valid_out (ppu_valid),
    .dma_start_in  (dma_start),
    .dma_src_hi_in (dma_src_hi),
    .dma_active_out(dma_active),
    .mem_addr_out  (mem_addr),
    .mem_rd_out    (mem_rd),
    .mem_wr_out    (mem_wr),
    .mem_wdata_out (mem_wdata),
    .mem_rdata_in  (mem_rdata),
    .mem_rvalid_in (mem_rvalid)
  );

  // memory: read data returned exactly one cycle after the strobe
  always @(posedge clk) begin
    mem_rvalid <= mem_rd;
    mem_rdata  <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] = mem_wdata;
  end

  function automatic bit cpu_blocked(input logic [15:0] a, input bit lcd,
                                     input logic [1:0] m, input bit dma);
    bit oam, vram;
    oam  = (a >= 16'hFE00) && (a <= 16'hFE9F);
    vram = (a >= 16'h8000) && (a <= 16'h9FFF);
    if (dma) return a[15:8] != 8'hFF;
    return lcd && ((oam && m >= 2) || (vram && m == 3));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({cpu_ack, ppu_valid, dma_active, mem_rd, mem_wr} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00000",
               {cpu_ack, ppu_valid, dma_active, mem_rd, mem_wr});
    end
    total++;
    if ({mem_addr, mem_wdata, cpu_rdata, ppu_data} !== 40'h0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0",
               {mem_addr, mem_wdata, cpu_rdata, ppu_data});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({cpu_ack, ppu_valid, dma_active, mem_rd, mem_wr} !== 5'b0) begin
      bad++;
      $display("FAIL post_reset_flags got=%b exp=00000",
               {cpu_ack, ppu_valid, dma_active, mem_rd, mem_wr});
    end
  endtask

  task automatic test_cpu_lock();
    logic [15:0] ta [6] = '{16'h8000, 16'h8000, 16'hFE10,
                            16'h8000, 16'hFE10, 16'hFE10};
    bit tw [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit tl [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] tm [6] = '{2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1};
    logic [15:0] bnd [8] = '{16'h7FFF, 16'h8000, 16'h9FFF, 16'hA000,
                             16'hFDFF, 16'hFE00, 16'hFE9F, 16'hFEA0};
    for (int i = 0; i < 30; i++) begin
      logic [15:0] a;
      bit w, l, blk;
      logic [1:0] m;
      logic [7:0] wd, old;
      logic [17:0] exp_bus;
      if (i < 6) begin
        a = ta[i]; w = tw[i]; l = tl[i]; m = tm[i];
      end else begin
        case ($urandom_range(0, 3))
          0: a = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
          1: a = 16'hFE00 + 16'($urandom_range(0, 159));
          2: a = bnd[$urandom_range(0, 7)];
          default: a = 16'hC000 + 16'($urandom_range(0, 16'h1FFF));
        endcase
        w = 1'($urandom_range(0, 1));
        l = 1'($urandom_range(0, 1));
        m = 2'($urandom_range(0, 3));
      end
      wd = 8'($urandom);
      if (i == 0) mem[16'h8000] = 8'h5A;
      old = mem[a];
      blk = cpu_blocked(a, l, m, 1'b0);
      exp_bus = blk ? 18'h0 : {!w, w, a};
      @(negedge clk);
      lcd_en = l; ppu_mode = m; cpu_addr = a;
      cpu_rd = !w; cpu_wr = w; cpu_wdata = wd;
      #1;
      total++;
      if ({mem_rd, mem_wr, mem_addr} !== exp_bus) begin
        bad++;
        $display("FAIL cpu_issue i=%0d got=%h exp=%h", i,
                 {mem_rd, mem_wr, mem_addr}, exp_bus);
      end
      @(negedge clk);
      #1;
      total++;
      if (cpu_ack !== 1'b1) begin
        bad++;
        $display("FAIL cpu_ack i=%0d got=%b exp=1", i, cpu_ack);
      end
      if (!w) begin
        total++;
        if (cpu_rdata !== (blk ? 8'hFF : old)) begin
          bad++;
          $display("FAIL cpu_rdata i=%0d a=%h got=%h exp=%h", i, a,
                   cpu_rdata, blk ? 8'hFF : old);
        end
      end else begin
        total++;
        if (mem[a] !== (blk ? old : wd)) begin
          bad++;
          $display("FAIL cpu_wmem i=%0d a=%h got=%h exp=%h", i, a,
                   mem[a], blk ? old : wd);
        end
      end
      cpu_rd = 1'b0; cpu_wr = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (cpu_ack !== 1'b0) begin
        bad++;
        $display("FAIL cpu_ack_once i=%0d got=%b exp=0", i, cpu_ack);
      end
    end
  endtask

  task automatic test_contention();
    lcd_en = 1'b1; ppu_mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] pa, ca;
      logic [7:0] epa, eca;
      pa = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
      ca = 16'hC000 + 16'($urandom_range(0, 16'h1FFF));
      epa = mem[pa]; eca = mem[ca];
      @(negedge clk);
      ppu_req = 1'b1; ppu_addr = pa; cpu_rd = 1'b1; cpu_addr = ca;
      #1;
      total++;
      if ({mem_rd, mem_addr} !== {1'b1, pa}) begin
        bad++;
        $display("FAIL ppu_first got=%h exp=%h", {mem_rd, mem_addr}, {1'b1, pa});
      end
      @(negedge clk);
      #1;
      total++;
      if ({ppu_valid, ppu_data} !== {1'b1, epa}) begin
        bad++;
        $display("FAIL ppu_data got=%h exp=%h", {ppu_valid, ppu_data}, {1'b1, epa});
      end
      total++;
      if ({mem_rd, mem_addr} !== {1'b1, ca}) begin
        bad++;
        $display("FAIL cpu_second got=%h exp=%h", {mem_rd, mem_addr}, {1'b1, ca});
      end
      ppu_req = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if ({cpu_ack, cpu_rdata, ppu_valid} !== {1'b1, eca, 1'b0}) begin
        bad++;
        $display("FAIL cpu_after_ppu got=%h exp=%h",
                 {cpu_ack, cpu_rdata, ppu_valid}, {1'b1, eca, 1'b0});
      end
      cpu_rd = 1'b0;
    end
  endtask

  task automatic test_dma();
    logic [7:0] src [160];
    int n_act, oerr;
    logic [17:0] exp_op;
    for (int i = 0; i < 160; i++) src[i] = mem[16'hC100 + 16'(i)];
    lcd_en = 1'b1; ppu_mode = 2'd0;
    @(negedge clk);
    dma_src_hi = 8'hC1; dma_start = 1'b1;
    @(negedge clk);
    dma_start = 1'b0;
    n_act = 0;
    for (int k = 0; k < 330; k++) begin
      #1;
      if (dma_active) n_act++;
      if (k >= 320) exp_op = 18'h0;
      else if (k % 2 == 0) exp_op = {2'b10, 16'hC100 + 16'(k / 2)};
      else exp_op = {2'b01, 16'hFE00 + 16'(k / 2)};
      total++;
      if ({mem_rd, mem_wr, mem_addr} !== exp_op) begin
        bad++;
        $display("FAIL dma_op k=%0d got=%h exp=%h", k,
                 {mem_rd, mem_wr, mem_addr}, exp_op);
      end
      if (k < 320 && k % 2 == 1) begin
        total++;
        if (mem_wdata !== src[k / 2]) begin
          bad++;
          $display("FAIL dma_wdata k=%0d got=%h exp=%h", k, mem_wdata, src[k / 2]);
        end
      end
      @(negedge clk);
    end
    total++;
    if (n_act != 320) begin
      bad++;
      $display("FAIL dma_active_len got=%0d exp=320", n_act);
    end
    oerr = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + 16'(i)] !== src[i]) oerr++;
    total++;
    if (oerr != 0) begin
      bad++;
      $display("FAIL dma_oam_copy wrong_bytes=%0d exp=0", oerr);
    end
  endtask

  task automatic test_dma_cpu();
    logic [7:0] exp_hi;
    bit got;
    @(negedge clk);
    dma_src_hi = 8'hC3; dma_start = 1'b1;
    @(negedge clk);
    dma_start = 1'b0;
    repeat (5) @(negedge clk);
    cpu_addr = 16'hC000; cpu_rd = 1'b1;
    #1;
    total++;
    if (mem_rd === 1'b1 && mem_addr === 16'hC000) begin
      bad++;
      $display("FAIL dma_cpu_nobus got=%h exp=not_C000", mem_addr);
    end
    @(negedge clk);
    #1;
    total++;
    if ({cpu_ack, cpu_rdata} !== {cpu_blocked(16'hC000, 1'b1, 2'd0, 1'b1), 8'hFF}) begin
      bad++;
      $display("FAIL dma_cpu_locked got=%h exp=1ff", {cpu_ack, cpu_rdata});
    end
    cpu_rd = 1'b0;
    @(negedge clk);
    exp_hi = mem[16'hFF80];
    cpu_addr = 16'hFF80; cpu_rd = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      #1;
      if (cpu_ack) got = 1'b1;
    end
    total++;
    if (got !== 1'b1 || cpu_rdata !== exp_hi) begin
      bad++;
      $display("FAIL dma_cpu_high got=%b/%h exp=1/%h", got, cpu_rdata, exp_hi);
    end
    cpu_rd = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_dma_ppu();
    logic [7:0] src [160];
    int oerr;
    bit done;
    for (int i = 0; i < 160; i++) src[i] = mem[16'hD200 + 16'(i)];
    lcd_en = 1'b1; ppu_mode = 2'd3;
    @(negedge clk);
    dma_src_hi = 8'hD2; dma_start = 1'b1;
    @(negedge clk);
    dma_start = 1'b0;
    done = 1'b0;
    for (int it = 0; it < 450 && !done; it++) begin
      if (!dma_active) done = 1'b1;
      else begin
        logic [15:0] pa;
        logic [7:0] ev;
        bit oam;
        oam = ($urandom_range(0, 2) == 0);
        pa = oam ? 16'hFE00 + 16'($urandom_range(0, 159))
                 : 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
        ev = oam ? 8'hFF : mem[pa];
        ppu_req = 1'b1; ppu_addr = pa;
        #1;
        total++;
        if (!oam && {mem_rd, mem_addr} !== {1'b1, pa}) begin
          bad++;
          $display("FAIL ppu_vram_gnt it=%0d got=%h exp=%h", it,
                   {mem_rd, mem_addr}, {1'b1, pa});
        end else if (oam && mem_rd === 1'b1 && mem_addr === pa) begin
          bad++;
          $display("FAIL ppu_oam_nobus it=%0d got=%h exp=no_read", it, mem_addr);
        end
        @(negedge clk);
        #1;
        total++;
        if ({ppu_valid, ppu_data} !== {1'b1, ev}) begin
          bad++;
          $display("FAIL ppu_dma_data it=%0d got=%h exp=%h", it,
                   {ppu_valid, ppu_data}, {1'b1, ev});
        end
        ppu_req = 1'b0;
        @(negedge clk);
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL dma_ppu_timeout got=active exp=idle");
    end
    oerr = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + 16'(i)] !== src[i]) oerr++;
    total++;
    if (oerr != 0) begin
      bad++;
      $display("FAIL dma_ppu_copy wrong_bytes=%0d exp=0", oerr);
    end
    ppu_mode = 2'd0;
  endtask

  task automatic test_restart();
    logic [7:0] src [160];
    logic [15:0] first_rd, first_wr;
    bit seen_rd, seen_wr;
    int n_act, oerr;
    for (int i = 0; i < 160; i++) src[i] = mem[16'hD000 + 16'(i)];
    @(negedge clk);
    dma_src_hi = 8'hC1; dma_start = 1'b1;
    @(negedge clk);
    dma_start = 1'b0;
    repeat (100) @(negedge clk);
    dma_src_hi = 8'hD0; dma_start = 1'b1;
    #1;
    total++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hC132}) begin
      bad++;
      $display("FAIL restart_pre got=%h exp=1c132", {mem_rd, mem_addr});
    end
    @(negedge clk);
    dma_start = 1'b0;
    seen_rd = 1'b0; seen_wr = 1'b0; n_act = 0;
    first_rd = 16'h0; first_wr = 16'h0;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (dma_active) n_act++;
      if (mem_rd && !seen_rd) begin seen_rd = 1'b1; first_rd = mem_addr; end
      if (mem_wr && !seen_wr) begin seen_wr = 1'b1; first_wr = mem_addr; end
      @(negedge clk);
    end
    total++;
    if (first_rd !== 16'hD000) begin
      bad++;
      $display("FAIL restart_rd got=%h exp=d000", first_rd);
    end
    total++;
    if (first_wr !== 16'hFE00) begin
      bad++;
      $display("FAIL restart_wr got=%h exp=fe00", first_wr);
    end
    total++;
    if (n_act != 320) begin
      bad++;
      $display("FAIL restart_len got=%0d exp=320", n_act);
    end
    oerr = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + 16'(i)] !== src[i]) oerr++;
    total++;
    if (oerr != 0) begin
      bad++;
      $display("FAIL restart_copy wrong_bytes=%0d exp=0", oerr);
    end
  endtask

  task automatic test_reset_mid_dma();
    int n_wr, n_act;
    @(negedge clk);
    dma_src_hi = 8'hC5; dma_start = 1'b1;
    @(negedge clk);
    dma_start = 1'b0;
    repeat (30) @(negedge clk);
    total++;
    if (dma_active !== 1'b1) begin
      bad++;
      $display("FAIL mid_dma_running got=%b exp=1", dma_active);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({dma_active, mem_rd, mem_wr} !== 3'b000) begin
      bad++;
      $display("FAIL reset_abort got=%b exp=000", {dma_active, mem_rd, mem_wr});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_wr = 0; n_act = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (mem_wr) n_wr++;
      if (dma_active) n_act++;
    end
    total++;
    if (n_wr != 0 || n_act != 0) begin
      bad++;
      $display("FAIL reset_no_resume got=wr%0d/act%0d exp=0/0", n_wr, n_act);
    end
  endtask

  initial begin
    rst = 1'b1;
    lcd_en = 1'b0; ppu_mode = 2'd0;
    cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;
    ppu_addr = '0; ppu_req = 1'b0;
    dma_start = 1'b0; dma_src_hi = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_cpu_lock();
    test_contention();
    test_dma();
    test_dma_cpu();
    test_dma_ppu();
    test_restart();
    test_reset_mid_dma();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
